// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM block.
package pwm_pkg;

  // Alignment of the PWM carrier.
  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  // Count direction of the center-aligned carrier.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  // Limit a duty value to 2^width; anything above means "always active".
  function automatic int unsigned duty_clamp(input int unsigned duty_val,
                                             input int unsigned width);
    int unsigned limit;
    limit = 32'd1 << width;
    return (duty_val > limit) ? limit : duty_val;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider: emits a one-cycle tick every max(timer_final_value, 1) clocks.
module pwm_prescaler #(
  parameter int unsigned TIMER_WIDTH = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [TIMER_WIDTH-1:0] timer_final_value,
  output logic                   tick
);

  localparam logic [TIMER_WIDTH-1:0] ONE = TIMER_WIDTH'(1);

  logic [TIMER_WIDTH-1:0] count_q, count_d;
  logic [TIMER_WIDTH-1:0] limit;

  // Terminal count and next count; a final value of 0 divides by one.
  always_comb begin
    limit   = (timer_final_value == '0) ? '0 : timer_final_value - ONE;
    tick    = en && (count_q >= limit);
    count_d = count_q;
    if (en) begin
      count_d = tick ? '0 : count_q + ONE;
    end
  end

  // Count register; held while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shared edge/center-aligned carrier and
// double-buffered duty settings that switch only at period boundaries.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned TIMER_WIDTH = 15,
  parameter int unsigned CHANNELS    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic [TIMER_WIDTH-1:0]          timer_final_value,
  input  logic [CHANNELS*(WIDTH+1)-1:0]   duty,
  input  logic                            duty_valid,
  input  logic                            center_mode,
  input  logic [CHANNELS-1:0]             polarity,
  output logic [CHANNELS-1:0]             pwm_out,
  output logic                            period_start,
  output logic                            duty_ack
);

  localparam int unsigned     DW      = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_CNT = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic                           tick;
  logic [WIDTH-1:0]               cnt_q, cnt_d;
  pwm_dir_e                       dir_q, dir_d;
  logic                           first_q, first_d;
  logic                           boundary;

  pwm_mode_e                      mode_q, mode_d;
  pwm_mode_e                      pend_mode_q, pend_mode_d;
  logic                           pend_flag_q, pend_flag_d;
  logic [CHANNELS-1:0][DW-1:0]    act_duty_q, act_duty_d;
  logic [CHANNELS-1:0][DW-1:0]    pend_duty_q, pend_duty_d;

  logic [CHANNELS-1:0]            pwm_q, pwm_d;
  logic                           period_start_q;
  logic                           duty_ack_q;
  wire  [CHANNELS-1:0]            cmp;

  pwm_prescaler #(
    .TIMER_WIDTH(TIMER_WIDTH)
  ) u_prescaler (
    .clk              (clk),
    .rst_n            (rst_n),
    .en               (en),
    .timer_final_value(timer_final_value),
    .tick             (tick)
  );

  // Carrier counter next state; the first tick after enable restarts the period at 0.
  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    first_d  = first_q;
    boundary = 1'b0;
    if (!en) begin
      cnt_d   = '0;
      dir_d   = DIR_UP;
      first_d = 1'b1;
    end else if (tick) begin
      first_d = 1'b0;
      if (first_q) begin
        cnt_d    = '0;
        dir_d    = DIR_UP;
        boundary = 1'b1;
      end else if (mode_q == MODE_EDGE) begin
        dir_d = DIR_UP;
        if (cnt_q == MAX_CNT) begin
          cnt_d    = '0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        unique case (dir_q)
          DIR_UP: begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == MAX_CNT - CNT_ONE) dir_d = DIR_DOWN;
          end
          DIR_DOWN: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              dir_d    = DIR_UP;
              boundary = 1'b1;
            end
          end
          default: begin
            dir_d = DIR_UP;
          end
        endcase
      end
    end
  end

  // Carrier state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      dir_q   <= DIR_UP;
      first_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      first_q <= first_d;
    end
  end

  // Settings double buffer: a boundary promotes the old pending value before a
  // coinciding duty_valid overwrites it, so the new value waits one period.
  always_comb begin
    mode_d      = mode_q;
    act_duty_d  = act_duty_q;
    pend_mode_d = pend_mode_q;
    pend_duty_d = pend_duty_q;
    pend_flag_d = pend_flag_q;
    if (boundary && pend_flag_q) begin
      mode_d      = pend_mode_q;
      act_duty_d  = pend_duty_q;
      pend_flag_d = 1'b0;
    end
    if (duty_valid) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        pend_duty_d[i] = DW'(duty_clamp(32'(duty[i*DW +: DW]), WIDTH));
      end
      pend_mode_d = pwm_mode_e'(center_mode);
      pend_flag_d = 1'b1;
    end
  end

  // Per-channel compare against the live counter.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign cmp[g] = ({1'b0, cnt_q} < act_duty_q[g]);
  end

  // Output level: inactive (polarity) whenever disabled.
  always_comb begin
    pwm_d = en ? (cmp ^ polarity) : polarity;
  end

  // Settings and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q         <= MODE_EDGE;
      act_duty_q     <= '0;
      pend_mode_q    <= MODE_EDGE;
      pend_duty_q    <= '0;
      pend_flag_q    <= 1'b0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
      duty_ack_q     <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      act_duty_q     <= act_duty_d;
      pend_mode_q    <= pend_mode_d;
      pend_duty_q    <= pend_duty_d;
      pend_flag_q    <= pend_flag_d;
      pwm_q          <= pwm_d;
      period_start_q <= boundary;
      duty_ack_q     <= boundary && pend_flag_q;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign duty_ack     = duty_ack_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: stimulus queues per-period expectations,
// the monitor measures each period between period_start pulses and compares.
module tb_pwm_multi;

  localparam int W  = 8;
  localparam int TW = 15;
  localparam int CH = 4;
  localparam int DW = W + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [TW-1:0]     tfv;
  logic [CH*DW-1:0]  duty;
  logic              duty_valid;
  logic              center_mode;
  logic [CH-1:0]     polarity;
  logic [CH-1:0]     pwm_out;
  logic              period_start;
  logic              duty_ack;

  always #5 clk = ~clk;

  pwm_multi #(
    .WIDTH      (W),
    .TIMER_WIDTH(TW),
    .CHANNELS   (CH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .en               (en),
    .timer_final_value(tfv),
    .duty             (duty),
    .duty_valid       (duty_valid),
    .center_mode      (center_mode),
    .polarity         (polarity),
    .pwm_out          (pwm_out),
    .period_start     (period_start),
    .duty_ack         (duty_ack)
  );

  typedef struct {
    string name;
    int    len;
    int    h0;
    int    h1;
    int    h2;
    int    h3;
    bit    ack;
  } rec_t;

  rec_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   ack_count = 0;
  int   stray_ack = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [CH*DW-1:0] pack(input int d0, input int d1, input int d2,
                                           input int d3);
    return {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  // Monitor: windows run from one period_start to the next; the closing sample
  // is included because pwm_out lags the counter by one clock.
  initial begin : monitor
    bit   in_win    = 1'b0;
    bit   start_ack = 1'b0;
    int   len       = 0;
    int   h[CH];
    rec_t r;
    forever begin
      @(negedge clk);
      if (duty_ack) begin
        ack_count++;
        if (!period_start) stray_ack++;
      end
      if (!rst_n || !en) begin
        in_win = 1'b0;
        continue;
      end
      if (in_win) begin
        len++;
        for (int k = 0; k < CH; k++) h[k] += int'(pwm_out[k]);
      end
      if (period_start) begin
        if (in_win && exp_q.size() > 0) begin
          r = exp_q.pop_front();
          check({r.name, " period length"}, len, r.len);
          check({r.name, " ch0 high"}, h[0], r.h0);
          check({r.name, " ch1 high"}, h[1], r.h1);
          check({r.name, " ch2 high"}, h[2], r.h2);
          check({r.name, " ch3 high"}, h[3], r.h3);
          check({r.name, " ack at start"}, int'(start_ack), int'(r.ack));
        end
        in_win    = 1'b1;
        len       = 0;
        for (int k = 0; k < CH; k++) h[k] = 0;
        start_ack = duty_ack;
      end
    end
  end

  task automatic send(input int d0, input int d1, input int d2, input int d3, input bit cm);
    @(posedge clk); #1;
    duty        = pack(d0, d1, d2, d3);
    center_mode = cm;
    duty_valid  = 1'b1;
    @(posedge clk); #1;
    duty_valid  = 1'b0;
  endtask

  task automatic expect_period(input string name, input int len, input int h0, input int h1,
                               input int h2, input int h3, input bit ack);
    rec_t r;
    r.name = name; r.len = len; r.h0 = h0; r.h1 = h1; r.h2 = h2; r.h3 = h3; r.ack = ack;
    @(posedge clk); #1;
    exp_q.push_back(r);
  endtask

  task automatic wait_ps(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 9000);
    if (!period_start) begin
      tests++;
      fails++;
      $display("FAIL %s: no period_start within %0d cycles, expected one", name, n);
    end
  endtask

  task automatic wait_popped(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 9000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s: period not measured within %0d cycles, expected it measured", name, n);
      exp_q.delete();
    end
  endtask

  initial begin : watchdog
    #700000;
    fails++;
    $display("FAIL watchdog: simulation still running, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int snap;
    rst_n = 1'b0; en = 1'b0; tfv = TW'(1); duty = '0; duty_valid = 1'b0;
    center_mode = 1'b0; polarity = '0;
    #2;
    check("reset pwm_out", int'(pwm_out), 0);
    check("reset period_start", int'(period_start), 0);
    check("reset duty_ack", int'(duty_ack), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Edge, tfv=1: settings captured while disabled, applied at first tick.
    send(128, 64, 192, 0, 1'b0);
    @(posedge clk); #1;
    en = 1'b1;
    wait_ps("enable latency", n);
    check("enable latency", n, 2);
    expect_period("edge first", 256, 128, 64, 192, 0, 1'b1);
    wait_popped("edge first");
    expect_period("edge steady", 256, 128, 64, 192, 0, 1'b0);
    wait_popped("edge steady");

    // Center mode, clamp and polarity.
    polarity = 4'b1000;
    send(0, 64, 256, 300, 1'b1);
    wait_ps("center", n);
    expect_period("center", 510, 0, 127, 510, 0, 1'b1);
    wait_popped("center");

    // Prescaler divide by 10, then tfv=0 behaves as 1.
    tfv = TW'(10);
    send(128, 1, 192, 256, 1'b0);
    wait_ps("tfv10", n);
    expect_period("tfv10", 2560, 1280, 10, 192 * 10, 0, 1'b1);
    wait_popped("tfv10");
    tfv = '0;
    wait_ps("tfv0", n);
    expect_period("tfv0", 256, 128, 1, 192, 0, 1'b0);
    wait_popped("tfv0");

    // Two updates within one period: last wins, single ack at the boundary.
    wait_ps("double update", n);
    expect_period("before boundary", 256, 128, 1, 192, 0, 1'b0);
    snap = ack_count;
    repeat (20) @(posedge clk);
    send(64, 1, 192, 256, 1'b0);
    repeat (20) @(posedge clk);
    send(200, 1, 192, 256, 1'b0);
    wait_popped("before boundary");
    expect_period("after boundary", 256, 200, 1, 192, 0, 1'b1);
    wait_popped("after boundary");
    check("duty_ack pulse count", ack_count - snap, 1);

    // Disable: outputs at polarity, live polarity, capture still works.
    @(posedge clk); #1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("disabled pwm_out", int'(pwm_out), 4'b1000);
    check("disabled period_start", int'(period_start), 0);
    check("disabled duty_ack", int'(duty_ack), 0);
    @(posedge clk); #1;
    polarity = 4'b0101;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("disabled live polarity", int'(pwm_out), 4'b0101);
    @(posedge clk); #1;
    polarity = 4'b1000;
    send(32, 1, 192, 0, 1'b0);
    @(posedge clk); #1;
    en = 1'b1;
    wait_ps("re-enable latency", n);
    check("re-enable latency", n, 2);
    expect_period("re-enable", 256, 32, 1, 192, 256, 1'b1);
    wait_popped("re-enable");

    // Reset mid-period with a pending update: update is lost.
    repeat (30) @(posedge clk);
    send(16, 1, 192, 0, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async reset pwm_out", int'(pwm_out), 0);
    check("async reset period_start", int'(period_start), 0);
    check("async reset duty_ack", int'(duty_ack), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ps("post-reset latency", n);
    check("post-reset latency", n, 2);
    expect_period("post-reset", 256, 0, 0, 0, 256, 1'b0);
    wait_popped("post-reset");

    check("duty_ack without period_start", stray_ack, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
